// File: rtl/fpu_op_scheduler.sv
// Two-requester front end for a single shared FPU: round-robin grant, one operation
// in flight, fixed-latency result capture and a valid/ready response port.
module fpu_op_scheduler #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [31:0] req0_A,
    input  logic [31:0] req0_B,
    input  logic [1:0]  req0_sel,
    input  logic [1:0]  req0_rm,
    input  logic [31:0] req1_A,
    input  logic [31:0] req1_B,
    input  logic [1:0]  req1_sel,
    input  logic [1:0]  req1_rm,
    output logic        fpu_start,
    output logic [31:0] fpu_A,
    output logic [31:0] fpu_B,
    output logic [1:0]  fpu_sel,
    output logic [1:0]  fpu_rm,
    input  logic [31:0] fpu_Y,
    input  logic        fpu_error,
    input  logic        fpu_overflow,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_Y,
    output logic        rsp_error,
    output logic        rsp_overflow,
    output logic        busy,
    output logic [15:0] op_count
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(LATENCY - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_last_grant;
    logic [3:0]  r_wait_cnt;
    logic [15:0] r_op_count;
    logic [31:0] r_fpu_a;
    logic [31:0] r_fpu_b;
    logic [1:0]  r_fpu_sel;
    logic [1:0]  r_fpu_rm;
    logic        r_rsp_id;
    logic [31:0] r_rsp_y;
    logic        r_rsp_error;
    logic        r_rsp_overflow;
    logic        w_grant;
    logic        w_req0_ready;
    logic        w_req1_ready;
    logic        w_accept;

    // Under contention the requester that did not win last time is chosen.
    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end
    end

    always_comb begin
        w_req0_ready = 1'b0;
        w_req1_ready = 1'b0;
        if (r_state == S_IDLE) begin
            w_req0_ready = req0_valid & ~w_grant;
            w_req1_ready = req1_valid & w_grant;
        end
    end

    assign w_accept = w_req0_ready | w_req1_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        fpu_start    = 1'b0;
        busy         = 1'b1;
        rsp_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_accept) begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                fpu_start    = 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (r_wait_cnt == 4'd0) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant   <= 1'b1;
            r_wait_cnt     <= 4'd0;
            r_op_count     <= 16'd0;
            r_fpu_a        <= 32'd0;
            r_fpu_b        <= 32'd0;
            r_fpu_sel      <= 2'd0;
            r_fpu_rm       <= 2'd0;
            r_rsp_id       <= 1'b0;
            r_rsp_y        <= 32'd0;
            r_rsp_error    <= 1'b0;
            r_rsp_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_fpu_a      <= w_grant ? req1_A   : req0_A;
                        r_fpu_b      <= w_grant ? req1_B   : req0_B;
                        r_fpu_sel    <= w_grant ? req1_sel : req0_sel;
                        r_fpu_rm     <= w_grant ? req1_rm  : req0_rm;
                        r_rsp_id     <= w_grant;
                        r_last_grant <= w_grant;
                    end
                end
                S_ISSUE: r_wait_cnt <= WAIT_LOAD;
                S_WAIT: begin
                    // Result is valid on the edge where the count has run out.
                    if (r_wait_cnt == 4'd0) begin
                        r_rsp_y        <= fpu_Y;
                        r_rsp_error    <= fpu_error;
                        r_rsp_overflow <= fpu_overflow;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_op_count <= r_op_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req0_ready   = w_req0_ready;
    assign req1_ready   = w_req1_ready;
    assign fpu_A        = r_fpu_a;
    assign fpu_B        = r_fpu_b;
    assign fpu_sel      = r_fpu_sel;
    assign fpu_rm       = r_fpu_rm;
    assign rsp_id       = r_rsp_id;
    assign rsp_Y        = r_rsp_y;
    assign rsp_error    = r_rsp_error;
    assign rsp_overflow = r_rsp_overflow;
    assign op_count     = r_op_count;

endmodule

// File: tb/tb_fpu_op_scheduler.sv
// Bench for fpu_op_scheduler: LATENCY=1 instance under a scoreboard plus directed steps,
// and a LATENCY=4 instance for the long-latency error case.
module tb_fpu_op_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid, b_req1_valid;
    logic [31:0] req0_A, req0_B, req1_A, req1_B;
    logic [1:0]  req0_sel, req0_rm, req1_sel, req1_rm;
    logic        rsp_ready, b_rsp_ready;

    logic        a_req0_ready, a_req1_ready, a_fpu_start, a_rsp_valid, a_rsp_id;
    logic        a_rsp_error, a_rsp_overflow, a_busy, a_fpu_error, a_fpu_overflow;
    logic [31:0] a_fpu_A, a_fpu_B, a_rsp_Y, a_fpu_Y;
    logic [1:0]  a_fpu_sel, a_fpu_rm;
    logic [15:0] a_op_count;

    logic        b_req0_ready, b_req1_ready, b_fpu_start, b_rsp_valid, b_rsp_id;
    logic        b_rsp_error, b_rsp_overflow, b_busy;
    logic [31:0] b_fpu_A, b_fpu_B, b_rsp_Y;
    logic [1:0]  b_fpu_sel, b_fpu_rm;
    logic [15:0] b_op_count;

    logic [33:0] a_pipe;
    logic [33:0] b_pipe [4];

    int          total = 0;
    int          bad = 0;
    logic [34:0] sb_q [$];
    logic        a_ids [$];
    logic        m_last;
    logic [15:0] m_count;
    logic [33:0] exp_b;

    always #5 clk = ~clk;

    fpu_op_scheduler #(.LATENCY(1)) dut_a (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(a_req0_ready), .req1_ready(a_req1_ready),
        .req0_A(req0_A), .req0_B(req0_B), .req0_sel(req0_sel), .req0_rm(req0_rm),
        .req1_A(req1_A), .req1_B(req1_B), .req1_sel(req1_sel), .req1_rm(req1_rm),
        .fpu_start(a_fpu_start), .fpu_A(a_fpu_A), .fpu_B(a_fpu_B),
        .fpu_sel(a_fpu_sel), .fpu_rm(a_fpu_rm),
        .fpu_Y(a_fpu_Y), .fpu_error(a_fpu_error), .fpu_overflow(a_fpu_overflow),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(a_rsp_id),
        .rsp_Y(a_rsp_Y), .rsp_error(a_rsp_error), .rsp_overflow(a_rsp_overflow),
        .busy(a_busy), .op_count(a_op_count)
    );

    fpu_op_scheduler #(.LATENCY(4)) dut_b (
        .clk(clk), .reset(reset),
        .req0_valid(1'b0), .req1_valid(b_req1_valid),
        .req0_ready(b_req0_ready), .req1_ready(b_req1_ready),
        .req0_A(req0_A), .req0_B(req0_B), .req0_sel(req0_sel), .req0_rm(req0_rm),
        .req1_A(req1_A), .req1_B(req1_B), .req1_sel(req1_sel), .req1_rm(req1_rm),
        .fpu_start(b_fpu_start), .fpu_A(b_fpu_A), .fpu_B(b_fpu_B),
        .fpu_sel(b_fpu_sel), .fpu_rm(b_fpu_rm),
        .fpu_Y(b_pipe[3][31:0]), .fpu_error(b_pipe[3][33]), .fpu_overflow(b_pipe[3][32]),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id),
        .rsp_Y(b_rsp_Y), .rsp_error(b_rsp_error), .rsp_overflow(b_rsp_overflow),
        .busy(b_busy), .op_count(b_op_count)
    );

    // Stand-in FPU: {error, overflow, Y}. 1.0 + 2.0 gives 3.0; other inputs give a tag value.
    function automatic logic [33:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] sel, input logic [1:0] rm);
        logic [31:0] y;
        if (a == 32'h3F80_0000 && b == 32'h4000_0000 && sel == 2'd0)
            y = 32'h4040_0000;
        else
            y = (a ^ {b[15:0], b[31:16]}) + {28'd0, rm, sel};
        return {sel == 2'd3, sel == 2'd2 && a[30] && b[30], y};
    endfunction

    always @(posedge clk) begin
        a_pipe <= a_fpu_start ? fpu_model(a_fpu_A, a_fpu_B, a_fpu_sel, a_fpu_rm) : 34'd0;
        b_pipe[0] <= b_fpu_start ? fpu_model(b_fpu_A, b_fpu_B, b_fpu_sel, b_fpu_rm) : 34'd0;
        for (int i = 1; i < 4; i++) b_pipe[i] <= b_pipe[i-1];
    end
    assign a_fpu_Y        = a_pipe[31:0];
    assign a_fpu_overflow = a_pipe[32];
    assign a_fpu_error    = a_pipe[33];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard for the LATENCY=1 instance: predict grant on accept, compare on handshake.
    always @(negedge clk) begin
        if (!reset) begin
            if ((req0_valid && a_req0_ready) || (req1_valid && a_req1_ready)) begin
                logic g;
                g = (req0_valid && req1_valid) ? ~m_last : req1_valid;
                check("grant", {30'd0, a_req1_ready, a_req0_ready}, g ? 32'd2 : 32'd1);
                sb_q.push_back({g, g ? fpu_model(req1_A, req1_B, req1_sel, req1_rm)
                                     : fpu_model(req0_A, req0_B, req0_sel, req0_rm)});
                m_last = g;
                $display("accept id=%0d", g);
            end
            if (a_rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    logic [34:0] e;
                    e = sb_q.pop_front();
                    check("rsp_id", {31'd0, a_rsp_id}, {31'd0, e[34]});
                    check("rsp_Y", a_rsp_Y, e[31:0]);
                    check("rsp_flags", {30'd0, a_rsp_error, a_rsp_overflow}, {30'd0, e[33:32]});
                    check("op_count_pre", {16'd0, a_op_count}, {16'd0, m_count});
                    m_count = m_count + 16'd1;
                    a_ids.push_back(a_rsp_id);
                    $display("response id=%0d Y=%h err=%0d ovf=%0d", a_rsp_id, a_rsp_Y,
                             a_rsp_error, a_rsp_overflow);
                end
            end
        end
    end

    task automatic wait_idle();
        int c = 0;
        while (a_busy && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("idle_timeout", {31'd0, a_busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 0; req1_valid = 0; b_req1_valid = 0;
        req0_A = 0; req0_B = 0; req0_sel = 0; req0_rm = 0;
        req1_A = 0; req1_B = 0; req1_sel = 0; req1_rm = 0;
        rsp_ready = 0; b_rsp_ready = 0;
        m_last = 1'b1; m_count = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, a_busy}, 32'd0);
        check("rst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
        check("rst_fpu_start", {31'd0, a_fpu_start}, 32'd0);
        check("rst_op_count", {16'd0, a_op_count}, 32'd0);
        check("rst_rsp_Y", a_rsp_Y, 32'd0);
        check("rst_fpu_A", a_fpu_A, 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // 1.0 + 2.0 from req0 with LATENCY=1; accept cycle counts as cycle 0
        req0_A = 32'h3F80_0000; req0_B = 32'h4000_0000; req0_sel = 2'd0; req0_rm = 2'd0;
        req0_valid = 1;
        @(negedge clk); check("t1_accept", {31'd0, a_req0_ready}, 32'd1);
        @(posedge clk); #1 req0_valid = 0;
        @(negedge clk);
        check("t1_start_c1", {31'd0, a_fpu_start}, 32'd1);
        check("t1_fpu_A", a_fpu_A, 32'h3F80_0000);
        @(negedge clk);
        check("t1_start_c2", {31'd0, a_fpu_start}, 32'd0);
        check("t1_valid_c2", {31'd0, a_rsp_valid}, 32'd0);
        @(negedge clk);
        check("t1_valid_c3", {31'd0, a_rsp_valid}, 32'd1);
        check("t1_Y", a_rsp_Y, 32'h4040_0000);
        check("t1_id", {31'd0, a_rsp_id}, 32'd0);

        // Response stalled 10 cycles while req0 waits
        @(posedge clk); #1;
        req0_A = 32'hC0A0_0000; req0_B = 32'h4120_0000; req0_sel = 2'd2; req0_rm = 2'd1;
        req0_valid = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall", {a_rsp_valid, a_req0_ready, a_rsp_Y[29:0]}, {2'b10, 30'h0040_0000});
        end
        @(posedge clk); #1 rsp_ready = 1;
        @(negedge clk); check("hs_no_accept", {31'd0, a_req0_ready}, 32'd0);
        @(posedge clk); #1 rsp_ready = 0;
        @(negedge clk);
        check("accept_after_hs", {31'd0, a_req0_ready}, 32'd1);
        check("op_count_1", {16'd0, a_op_count}, 32'd1);
        @(posedge clk); #1 req0_valid = 0; rsp_ready = 1;
        wait_idle();

        // Reset during WAIT aborts the operation
        rsp_ready = 0;
        @(posedge clk); #1 req0_valid = 1;
        @(posedge clk); #1 req0_valid = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        sb_q.delete(); m_last = 1'b1; m_count = 16'd0;
        #1;
        check("rstw_busy", {31'd0, a_busy}, 32'd0);
        check("rstw_valid", {31'd0, a_rsp_valid}, 32'd0);
        check("rstw_start", {31'd0, a_fpu_start}, 32'd0);
        check("rstw_op_count", {16'd0, a_op_count}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (4) @(negedge clk);
        check("rstw_no_rsp", {31'd0, a_rsp_valid}, 32'd0);

        // Round robin under continuous contention
        a_ids.delete();
        rsp_ready = 1;
        req0_A = 32'h1111_0000; req0_B = 32'h0000_2222; req0_sel = 2'd1; req0_rm = 2'd2;
        req1_A = 32'h4100_0000; req1_B = 32'h4080_0000; req1_sel = 2'd2; req1_rm = 2'd3;
        @(posedge clk); #1 req0_valid = 1; req1_valid = 1;
        for (int c = 0; c < 200 && m_count < 16'd4; c++) @(negedge clk);
        check("rr_done", {16'd0, m_count}, 32'd4);
        @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
        wait_idle();
        for (int i = 0; i < 4; i++)
            check("rr_id", {31'd0, a_ids[i]}, i % 2);

        // LATENCY=4 divide from req1 with error flagged by the FPU
        req1_A = 32'h4049_0FDB; req1_B = 32'h0000_0000; req1_sel = 2'd3; req1_rm = 2'd0;
        exp_b = fpu_model(req1_A, req1_B, req1_sel, req1_rm);
        b_rsp_ready = 0;
        @(posedge clk); #1 b_req1_valid = 1;
        @(negedge clk);
        check("b_accept", {30'd0, b_req1_ready, b_req0_ready}, 32'd2);
        @(posedge clk); #1 b_req1_valid = 0;
        @(negedge clk); check("b_start_c1", {31'd0, b_fpu_start}, 32'd1);
        repeat (4) @(negedge clk);
        check("b_valid_c5", {31'd0, b_rsp_valid}, 32'd0);
        @(negedge clk);
        check("b_valid_c6", {31'd0, b_rsp_valid}, 32'd1);
        check("b_error", {30'd0, b_rsp_error, b_rsp_overflow}, 32'd2);
        check("b_id", {31'd0, b_rsp_id}, 32'd1);
        check("b_Y", b_rsp_Y, exp_b[31:0]);
        check("b_count0", {16'd0, b_op_count}, 32'd0);
        $display("response(L4) id=%0d Y=%h err=%0d", b_rsp_id, b_rsp_Y, b_rsp_error);
        @(posedge clk); #1 b_rsp_ready = 1;
        @(posedge clk); #1 b_rsp_ready = 0;
        @(negedge clk);
        check("b_count1", {16'd0, b_op_count}, 32'd1);
        check("b_idle", {31'd0, b_busy}, 32'd0);

        // Completion counter wrap from 0xFFFF
        @(negedge clk);
        force dut_a.r_op_count = 16'hFFFF;
        #1 release dut_a.r_op_count;
        m_count = 16'hFFFF;
        #1 check("preset", {16'd0, a_op_count}, 32'h0000_FFFF);
        req0_sel = 2'd0; req0_rm = 2'd1;
        @(posedge clk); #1 req0_valid = 1;
        @(posedge clk); #1 req0_valid = 0;
        wait_idle();
        @(negedge clk);
        check("wrap", {16'd0, a_op_count}, 32'd0);
        check("sb_empty", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
